fetch_sequencer: RTL

Controller that sequences the program counter of the P4 MIPS core: it holds the PC register, issues instruction-memory read requests over a req/ack handshake, delivers each fetched instruction to decode with a valid/stall handshake, applies branch/jump redirects and halts or faults on illegal fetch addresses. It replaces free-running `NPC -> PC` updating with a controlled fetch loop between the PC and the instruction memory.

---
 rtl/fetch_seq_pkg.sv | 17 +
 rtl/fetch_addr_check.sv | 15 +
 rtl/fetch_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// default fetch-window bounds and the instruction word width.
package fetch_seq_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_PC_MAX   = 32'h0000_6FFC;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_ISSUE,
    ST_HALTED,
    ST_FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch-address legality: word aligned and inside the
// inclusive [LO, HI] window.
module fetch_addr_check
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] LO = DEF_RESET_PC,
  parameter logic [31:0] HI = DEF_PC_MAX
) (
  input  logic [INSTR_W-1:0] i_addr,
  output logic               o_legal
);

  assign o_legal = (i_addr[1:0] == 2'b00) && (i_addr >= LO) && (i_addr <= HI);

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer for the P4 MIPS core: fetches over a req/ack memory port,
// hands instructions to decode via valid/stall, applies redirects, halts or faults.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_MAX   = DEF_PC_MAX
) (
  input  logic               clk,
  input  logic               reset,
  output logic               im_req,
  output logic [31:0]        im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic [31:0]        pc,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        fault_pc,
  output logic [31:0]        issue_cnt
);

  fetch_state_t       r_state;
  logic [31:0]        r_pc;
  logic               r_im_req;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_instr_pc;
  logic               r_halted;
  logic               r_fault;
  logic [31:0]        r_fault_pc;
  logic [31:0]        r_issue_cnt;
  logic               r_pend_valid;
  logic [31:0]        r_pend_pc;

  logic               w_redir_any;
  logic [31:0]        w_redir_pc;
  logic [31:0]        w_next_pc;
  logic               w_next_legal;

  // A redirect arriving this cycle is newer than anything pending.
  assign w_redir_any = redirect_valid | r_pend_valid;
  assign w_redir_pc  = redirect_valid ? redirect_pc : r_pend_pc;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next_pc = r_pc;
    case (r_state)
      ST_FETCH: w_next_pc = w_redir_pc;
      ST_ISSUE: w_next_pc = w_redir_any ? w_redir_pc : r_pc + 32'd4;
      default:  w_next_pc = r_pc;
    endcase
  end

  fetch_addr_check #(
    .LO(RESET_PC),
    .HI(PC_MAX)
  ) u_addr_check (
    .i_addr (w_next_pc),
    .o_legal(w_next_legal)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_im_req      <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
      r_issue_cnt   <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_pc     <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (w_next_legal) begin
            r_state  <= ST_FETCH;
            r_im_req <= 1'b1;
          end else begin
            r_state    <= ST_FAULT;
            r_fault    <= 1'b1;
            r_fault_pc <= w_next_pc;
          end
        end

        ST_FETCH: begin
          if (im_ack) begin
            if (w_redir_any) begin
              // Fetched word belongs to the wrong path: drop it and refetch.
              r_pend_valid <= 1'b0;
              if (w_next_legal) begin
                r_pc <= w_next_pc;
              end else begin
                r_state    <= ST_FAULT;
                r_im_req   <= 1'b0;
                r_fault    <= 1'b1;
                r_fault_pc <= w_next_pc;
              end
            end else begin
              r_instr       <= im_rdata;
              r_instr_pc    <= r_pc;
              r_im_req      <= 1'b0;
              r_instr_valid <= 1'b1;
              r_state       <= ST_ISSUE;
            end
          end else if (redirect_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= redirect_pc;
          end
        end

        ST_ISSUE: begin
          if (!stall) begin
            r_instr_valid <= 1'b0;
            r_issue_cnt   <= r_issue_cnt + 32'd1;
            r_pend_valid  <= 1'b0;
            if (halt) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else if (w_next_legal) begin
              r_pc     <= w_next_pc;
              r_state  <= ST_FETCH;
              r_im_req <= 1'b1;
            end else begin
              r_state    <= ST_FAULT;
              r_fault    <= 1'b1;
              r_fault_pc <= w_next_pc;
            end
          end else if (redirect_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= redirect_pc;
          end
        end

        default: r_state <= r_state;
      endcase
    end
  end

  assign im_req      = r_im_req;
  assign im_addr     = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;
  assign issue_cnt   = r_issue_cnt;

endmodule
